// File: rtl/kypd_scanner_if.sv
// ---------------------------------------------------------------------------
// kypd_scanner_if
// Bundles the keypad matrix lines and the decoded-key outputs of the scanner.
//
// Signals:
//   Row       [3:0]  keypad rows, active-low, pulled up externally (async)
//   Col       [3:0]  keypad column drive, exactly one bit low
//   key_code  [3:0]  hex code of the most recently accepted key
//   key_valid        one-cycle pulse when a new key is accepted
//   key_down         high while an accepted key is held
//
// Modports:
//   master  - the scanner: reads Row, drives everything else
//   slave   - the keypad / consumer side: drives Row, reads everything else
// ---------------------------------------------------------------------------
interface kypd_scanner_if;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  Row,
    output Col,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output Row,
    input  Col,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/kypd_scanner.sv
// ---------------------------------------------------------------------------
// kypd_scanner
// Scans a 4x4 matrix keypad one column at a time, debounces whole-scan
// results, and reports accepted keys as a hex code with a one-cycle pulse.
//
// Parameters:
//   SCAN_DIV        clk cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  identical consecutive full scans needed to accept (1..15)
//
// Ports:
//   clk    input   system clock, rising edge
//   rst_n  input   synchronous active-low reset
//   kp     master  keypad interface (Row in; Col, key_code, key_valid,
//                  key_down out)
// ---------------------------------------------------------------------------
module kypd_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  kypd_scanner_if.master  kp
);

  localparam int              DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]   DWELL_ONE  = DW'(1);
  localparam logic [3:0]      DEB_MAX    = 4'(DEBOUNCE_SCANS);

  typedef enum logic {
    IDLE,
    PRESSED
  } state_t;

  // Fixed keypad legend indexed by (column, row).
  function automatic logic [3:0] keyMap(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    code = 4'h0;
    case ({col, row})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hF;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hE;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  logic [3:0]    rowMeta_q, rowSync_q;
  logic [DW-1:0] dwellCnt_q, dwellCnt_d;
  logic [1:0]    colIdx_q, colIdx_d;
  logic          scanHit_q, scanHit_d;
  logic [3:0]    scanCode_q, scanCode_d;
  logic          evalPend_q, evalPend_d;
  logic          prevHit_q, prevHit_d;
  logic [3:0]    prevCode_q, prevCode_d;
  logic [3:0]    stableCnt_q, stableCnt_d;
  logic [3:0]    keyCode_q, keyCode_d;
  logic          keyValid_q, keyValid_d;
  state_t        state_q, state_d;

  logic          lastDwell;
  logic [3:0]    rowHit;
  logic          anyRow;
  logic [1:0]    lowRow;
  logic          settled;
  logic          loadKey;
  logic [3:0]    colDrive;

  // Row inputs are asynchronous to clk; idle (pulled-up) value is all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rowMeta_q <= 4'b1111;
      rowSync_q <= 4'b1111;
    end else begin
      rowMeta_q <= kp.Row;
      rowSync_q <= rowMeta_q;
    end
  end

  // Column dwell timing and per-column sampling into the running scan result.
  // The code is forced to zero on a miss so that two empty scans compare equal.
  always_comb begin
    lastDwell  = (dwellCnt_q == DWELL_LAST);
    rowHit     = ~rowSync_q;
    anyRow     = |rowHit;

    lowRow = 2'd0;
    if (rowHit[0])      lowRow = 2'd0;
    else if (rowHit[1]) lowRow = 2'd1;
    else if (rowHit[2]) lowRow = 2'd2;
    else if (rowHit[3]) lowRow = 2'd3;

    dwellCnt_d = dwellCnt_q + DWELL_ONE;
    colIdx_d   = colIdx_q;
    scanHit_d  = scanHit_q;
    scanCode_d = scanCode_q;
    evalPend_d = 1'b0;

    if (lastDwell) begin
      dwellCnt_d = '0;
      colIdx_d   = colIdx_q + 2'd1;
      evalPend_d = (colIdx_q == 2'd3);
      if (colIdx_q == 2'd0) begin
        scanHit_d  = anyRow;
        scanCode_d = anyRow ? keyMap(colIdx_q, lowRow) : 4'h0;
      end else if (!scanHit_q && anyRow) begin
        scanHit_d  = 1'b1;
        scanCode_d = keyMap(colIdx_q, lowRow);
      end
    end
  end

  // Debounce on whole-scan results, one evaluation per scan.
  always_comb begin
    stableCnt_d = stableCnt_q;
    prevHit_d   = prevHit_q;
    prevCode_d  = prevCode_q;
    if (evalPend_q) begin
      prevHit_d  = scanHit_q;
      prevCode_d = scanCode_q;
      if ({scanHit_q, scanCode_q} != {prevHit_q, prevCode_q}) begin
        stableCnt_d = 4'd1;
      end else if (stableCnt_q < DEB_MAX) begin
        stableCnt_d = stableCnt_q + 4'd1;
      end
    end
    settled = evalPend_q && (stableCnt_d == DEB_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwellCnt_q  <= '0;
      colIdx_q    <= 2'd0;
      scanHit_q   <= 1'b0;
      scanCode_q  <= 4'h0;
      evalPend_q  <= 1'b0;
      prevHit_q   <= 1'b0;
      prevCode_q  <= 4'h0;
      stableCnt_q <= 4'd0;
      keyCode_q   <= 4'h0;
      keyValid_q  <= 1'b0;
    end else begin
      dwellCnt_q  <= dwellCnt_d;
      colIdx_q    <= colIdx_d;
      scanHit_q   <= scanHit_d;
      scanCode_q  <= scanCode_d;
      evalPend_q  <= evalPend_d;
      prevHit_q   <= prevHit_d;
      prevCode_q  <= prevCode_d;
      stableCnt_q <= stableCnt_d;
      keyCode_q   <= keyCode_d;
      keyValid_q  <= keyValid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A settled hit with a new code (from IDLE, or a different key while
  // PRESSED) loads the code and pulses key_valid; a settled miss releases.
  always_comb begin
    state_d = state_q;
    loadKey = 1'b0;
    case (state_q)
      IDLE: begin
        if (settled && scanHit_q) begin
          state_d = PRESSED;
          loadKey = 1'b1;
        end
      end
      PRESSED: begin
        if (settled && !scanHit_q) begin
          state_d = IDLE;
        end else if (settled && (scanCode_q != keyCode_q)) begin
          loadKey = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    keyValid_d = loadKey;
    keyCode_d  = loadKey ? scanCode_q : keyCode_q;
  end

  always_comb begin
    colDrive           = 4'b1111;
    colDrive[colIdx_q] = 1'b0;
  end

  assign kp.Col       = colDrive;
  assign kp.key_code  = keyCode_q;
  assign kp.key_valid = keyValid_q;
  assign kp.key_down  = (state_q == PRESSED);

endmodule

// File: tb/tb_kypd_scanner.sv
// ---------------------------------------------------------------------------
// tb_kypd_scanner
// Self-checking bench for kypd_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// A behavioural keypad pulls a row low whenever a pressed key's column is
// driven low. A table walks every key of the legend; hand-written sequences
// cover idle scanning, hold/release, priority and rollover, glitches and
// reset in the middle of a press.
// ---------------------------------------------------------------------------
module tb_kypd_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic [3:0]  rowModel;
  int          total = 0;
  int          bad = 0;
  int          pulseCnt = 0;
  int          base;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[16];

  kypd_scanner_if kif ();

  kypd_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // Keypad: key index is col*4+row; a pressed key shorts its row to its column.
  always_comb begin
    rowModel = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !kif.Col[c]) rowModel[r] = 1'b0;
      end
    end
  end
  assign kif.Row = rowModel;

  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) pulseCnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
  endtask

  // Leaves the bench at the negedge in the first cycle of column 0.
  task automatic alignScanStart();
    logic [3:0] last;
    logic       found;
    found = 1'b0;
    last  = kif.Col;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (last == 4'b0111 && kif.Col == 4'b1110) begin
        found = 1'b1;
        break;
      end
      last = kif.Col;
    end
    checkOutput("align", {31'd0, found}, 32'd1);
  endtask

  task automatic waitDown(input string name, input logic want, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (kif.key_down === want) break;
      @(negedge clk);
    end
    checkOutput(name, {31'd0, kif.key_down}, {31'd0, want});
  endtask

  initial begin
    vecs[0]  = '{16'h0001, 4'h1};
    vecs[1]  = '{16'h0002, 4'h4};
    vecs[2]  = '{16'h0004, 4'h7};
    vecs[3]  = '{16'h0008, 4'h0};
    vecs[4]  = '{16'h0010, 4'h2};
    vecs[5]  = '{16'h0020, 4'h5};
    vecs[6]  = '{16'h0040, 4'h8};
    vecs[7]  = '{16'h0080, 4'hF};
    vecs[8]  = '{16'h0100, 4'h3};
    vecs[9]  = '{16'h0200, 4'h6};
    vecs[10] = '{16'h0400, 4'h9};
    vecs[11] = '{16'h0800, 4'hE};
    vecs[12] = '{16'h1000, 4'hA};
    vecs[13] = '{16'h2000, 4'hB};
    vecs[14] = '{16'h4000, 4'hC};
    vecs[15] = '{16'h8000, 4'hD};

    // Reset state.
    applyStimulus(16'h0000);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_col",   {28'd0, kif.Col},      32'hE);
    checkOutput("rst_code",  {28'd0, kif.key_code}, 32'h0);
    checkOutput("rst_valid", {31'd0, kif.key_valid}, 32'd0);
    checkOutput("rst_down",  {31'd0, kif.key_down}, 32'd0);

    // Idle scan: column i/4 low during cycle i after reset release.
    rst_n = 1'b1;
    base  = pulseCnt;
    for (int i = 0; i < 64; i++) begin
      logic [3:0] expCol;
      expCol = 4'b1111;
      expCol[(i / 4) % 4] = 1'b0;
      checkOutput($sformatf("idle_col%0d", i), {28'd0, kif.Col}, {28'd0, expCol});
      @(negedge clk);
    end
    checkOutput("idle_pulses", pulseCnt - base, 32'd0);

    // Key legend table: press aligned, expect one pulse; release.
    for (int v = 0; v < 16; v++) begin
      alignScanStart();
      base = pulseCnt;
      applyStimulus(vecs[v].keys);
      repeat (36) @(negedge clk);
      checkOutput($sformatf("tbl%0d_code", v), {28'd0, kif.key_code}, {28'd0, vecs[v].code});
      checkOutput($sformatf("tbl%0d_down", v), {31'd0, kif.key_down}, 32'd1);
      checkOutput($sformatf("tbl%0d_pulses", v), pulseCnt - base, 32'd1);
      applyStimulus(16'h0000);
      waitDown($sformatf("tbl%0d_release", v), 1'b0, 64);
    end

    // Press "5", hold without repeats, then release.
    alignScanStart();
    base = pulseCnt;
    applyStimulus(16'h0020);
    repeat (36) @(negedge clk);
    checkOutput("press5_code",   {28'd0, kif.key_code}, 32'h5);
    checkOutput("press5_down",   {31'd0, kif.key_down}, 32'd1);
    checkOutput("press5_pulses", pulseCnt - base, 32'd1);
    repeat (64) @(negedge clk);
    checkOutput("hold5_pulses",  pulseCnt - base, 32'd1);
    base = pulseCnt;
    applyStimulus(16'h0000);
    waitDown("rel5_down", 1'b0, 64);
    repeat (4) @(negedge clk);
    checkOutput("rel5_code",   {28'd0, kif.key_code}, 32'h5);
    checkOutput("rel5_pulses", pulseCnt - base, 32'd0);

    // Priority: "9" (col2,row2) beats "A" (col3,row0); then rollover to "A".
    alignScanStart();
    base = pulseCnt;
    applyStimulus(16'h1400);
    repeat (36) @(negedge clk);
    checkOutput("prio_code",   {28'd0, kif.key_code}, 32'h9);
    checkOutput("prio_pulses", pulseCnt - base, 32'd1);
    base = pulseCnt;
    applyStimulus(16'h1000);
    repeat (56) @(negedge clk);
    checkOutput("roll_code",   {28'd0, kif.key_code}, 32'hA);
    checkOutput("roll_down",   {31'd0, kif.key_down}, 32'd1);
    checkOutput("roll_pulses", pulseCnt - base, 32'd1);
    applyStimulus(16'h0000);
    waitDown("roll_release", 1'b0, 64);

    // Glitch: "0" held for exactly one scan.
    alignScanStart();
    base = pulseCnt;
    applyStimulus(16'h0008);
    repeat (16) @(negedge clk);
    applyStimulus(16'h0000);
    for (int i = 0; i < 64; i++) begin
      if (kif.key_down !== 1'b0) break;
      @(negedge clk);
    end
    checkOutput("glitch_down",   {31'd0, kif.key_down}, 32'd0);
    checkOutput("glitch_pulses", pulseCnt - base, 32'd0);
    checkOutput("glitch_code",   {28'd0, kif.key_code}, 32'hA);

    // Reset while "D" is held, then re-acceptance of "D".
    alignScanStart();
    applyStimulus(16'h8000);
    waitDown("d_down", 1'b1, 64);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_col",   {28'd0, kif.Col},      32'hE);
    checkOutput("midrst_code",  {28'd0, kif.key_code}, 32'h0);
    checkOutput("midrst_valid", {31'd0, kif.key_valid}, 32'd0);
    checkOutput("midrst_down",  {31'd0, kif.key_down}, 32'd0);
    @(negedge clk);
    base  = pulseCnt;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("redo_code",   {28'd0, kif.key_code}, 32'hD);
    checkOutput("redo_down",   {31'd0, kif.key_down}, 32'd1);
    checkOutput("redo_pulses", pulseCnt - base, 32'd1);
    repeat (48) @(negedge clk);
    checkOutput("redo_hold_pulses", pulseCnt - base, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kypd_scanner.md
KYPD_SCANNER -- requirements
Module: kypd_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each column is driven (1 ms at 100 MHz); legal range >= 4.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive identical full-scan results needed to accept a change; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port Row  input  4  keypad rows; active-low, externally pulled up; asynchronous to clk.
REQ-006 SHALL have port Col  output  4  keypad column drive; exactly one bit low (active column), others high.
REQ-007 SHALL have port key_code  output  4  hex code of the accepted key; holds its value after release.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_down  output  1  high while an accepted key is held.

Function
REQ-010 SHALL pass Row through a 2-flop synchronizer before any use.
REQ-011 SHALL drive column c (0..3) as Col = 4'b1111 with bit c cleared, for exactly SCAN_DIV cycles, then advance to c+1, wrapping 3->0.
REQ-012 SHALL sample the synchronized rows in the last cycle of each column dwell (dwell counter == SCAN_DIV-1) only.
REQ-013 SHALL map (col,row) to key_code as: col0 rows0-3 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
REQ-014 SHALL form one scan result per full scan (columns 0..3), as {hit, code}; with several keys down, the lowest column wins, then the lowest row within that column.
REQ-015 SHALL evaluate the scan result in the cycle after the column-3 sample.
REQ-016 SHALL keep a stable counter: reload to 1 when the result differs from the previous scan result; increment when equal, saturating at DEBOUNCE_SCANS.
REQ-017 SHALL have two states, IDLE and PRESSED.
  - IDLE->PRESSED when the stable count reaches DEBOUNCE_SCANS with hit=1.
  - PRESSED->IDLE when it reaches DEBOUNCE_SCANS with hit=0.
  - PRESSED->PRESSED (rollover) when it reaches DEBOUNCE_SCANS with hit=1 and a code different from key_code.
REQ-018 SHALL, on IDLE->PRESSED or rollover, load key_code and pulse key_valid high for exactly one cycle, registered in the cycle after evaluation.
REQ-019 SHALL set key_down = 1 in PRESSED and 0 in IDLE; key_code SHALL NOT change on release.
REQ-020 SHALL NOT generate repeated key_valid pulses while the same key stays held.
REQ-021 SHALL give, for a clean press aligned to a scan start, key_valid within DEBOUNCE_SCANS*4*SCAN_DIV + 4 cycles.
REQ-022 SHALL ignore glitches shorter than DEBOUNCE_SCANS full scans (no key_valid, key_down unchanged).

Reset
REQ-023 SHALL, while rst_n=0 at a clk edge, set: Col=4'b1110, dwell and column counters=0, synchronizer=4'b1111, previous result={0,0}, stable count=0, state=IDLE, key_code=0, key_valid=0, key_down=0.
REQ-024 SHALL, on reset asserted mid-press, abandon the press without a pulse and re-debounce from scratch after release of reset.
REQ-025 SHALL start the first scan at column 0 on the first cycle after rst_n goes high.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2; keypad model pulls Row low when the key's column is low)
REQ-026 SHALL check idle scan: no key, 64 cycles -> Col sequence 1110,1101,1011,0111 each held 4 cycles, repeating; key_valid never high.
REQ-027 SHALL check press: hold key "5" (col1,row1) -> single key_valid pulse, key_code=4'h5, key_down=1 within 36 cycles; no further pulses while held.
REQ-028 SHALL check release: release "5" -> key_down=0 after 2 clean scans, key_code stays 4'h5, no key_valid.
REQ-029 SHALL check priority and rollover: hold "9" and "A" together -> key_code=4'h9; then release "9" while "A" held -> one key_valid pulse, key_code=4'hA.
REQ-030 SHALL check a glitch: press "0" for one scan only -> no key_valid, key_down stays 0.
REQ-031 SHALL check reset while "D" is held and key_down=1 -> all outputs 0, Col=1110; after reset, "D" re-accepted with one key_valid pulse.
